// File: rtl/writeback_hazard_if.sv
// Bundles the EX, data-memory, DOF and register-file sides of the write-back
// hazard unit. The pipeline drives the master side; the hazard unit is the slave.
interface writeback_hazard_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    // EX stage and data memory
    logic          ex_valid;
    logic          ex_rw;
    logic          ex_md;
    logic [AW-1:0] ex_da;
    logic [DW-1:0] ex_f;
    logic [DW-1:0] mem_rdata;
    // DOF stage operand requests
    logic          dof_valid;
    logic [AW-1:0] dof_aa;
    logic [AW-1:0] dof_ba;
    logic          dof_ma;
    logic          dof_mb;
    // Register file write port, operand-mux controls and pipeline control
    logic             RW;
    logic [AW-1:0]    DA;
    logic [DW-1:0]    BUS_D;
    logic             HA;
    logic             HB;
    logic [DW-1:0]    FWD;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_valid, ex_rw, ex_md, ex_da, ex_f, mem_rdata,
        output dof_valid, dof_aa, dof_ba, dof_ma, dof_mb,
        input  RW, DA, BUS_D, HA, HB, FWD, stall, bubble, stall_cnt
    );

    modport slave (
        input  ex_valid, ex_rw, ex_md, ex_da, ex_f, mem_rdata,
        input  dof_valid, dof_aa, dof_ba, dof_ma, dof_mb,
        output RW, DA, BUS_D, HA, HB, FWD, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/writeback_hazard_unit.sv
// Write-back side of the register file: owns the EX/WB pipeline register, drives
// the file write port, and resolves DOF read-after-write hazards by forwarding
// the EX result where legal or stalling DOF and bubbling EX otherwise.
module writeback_hazard_unit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_hazard_if.slave  bus
);

    logic             wb_valid_q;
    logic             wb_rw_q;
    logic             wb_md_q;
    logic [AW-1:0]    wb_da_q;
    logic [DW-1:0]    wb_f_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic rw;
    logic need_a, need_b;
    logic ex_a, ex_b, wb_a, wb_b;
    logic fwd_a, fwd_b, haz_a, haz_b;
    logic stall;

    // EX/WB register: EX always advances, so capture is never gated by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_md_q    <= 1'b0;
            wb_da_q    <= '0;
            wb_f_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            wb_valid_q <= bus.ex_valid;
            wb_rw_q    <= bus.ex_rw;
            wb_md_q    <= bus.ex_md;
            wb_da_q    <= bus.ex_da;
            wb_f_q     <= bus.ex_f;
        end
    end

    // Hazard detection: EX match beats WB match because EX holds the newer value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        rw     = wb_valid_q & wb_rw_q & (wb_da_q != '0);
        need_a = bus.dof_valid & ~bus.dof_ma & (bus.dof_aa != '0);
        need_b = bus.dof_valid & ~bus.dof_mb & (bus.dof_ba != '0);
        ex_a   = bus.ex_valid & bus.ex_rw & (bus.ex_da == bus.dof_aa);
        ex_b   = bus.ex_valid & bus.ex_rw & (bus.ex_da == bus.dof_ba);
        wb_a   = rw & (wb_da_q == bus.dof_aa);
        wb_b   = rw & (wb_da_q == bus.dof_ba);
        // A load result only exists in WB, and WB data has no forward path:
        // the file write lands at the end of the cycle, so the reader waits.
        fwd_a  = need_a & ex_a & ~bus.ex_md;
        fwd_b  = need_b & ex_b & ~bus.ex_md;
        haz_a  = need_a & ((ex_a & bus.ex_md) | (~ex_a & wb_a));
        haz_b  = need_b & ((ex_b & bus.ex_md) | (~ex_b & wb_b));
        stall  = haz_a | haz_b;
    end

    // Stall counter next state: count stalled cycles, hold at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.RW        = rw;
    assign bus.DA        = wb_da_q;
    assign bus.BUS_D     = wb_md_q ? bus.mem_rdata : wb_f_q;
    assign bus.FWD       = bus.ex_f;
    // A stalled DOF reads nothing this cycle, so forwarding selects are dropped.
    assign bus.HA        = fwd_a & ~stall;
    assign bus.HB        = fwd_b & ~stall;
    assign bus.stall     = stall;
    assign bus.bubble    = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_writeback_hazard_unit.sv
// Directed bench for writeback_hazard_unit: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_writeback_hazard_unit;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    writeback_hazard_if #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) bus ();

    writeback_hazard_unit #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.ex_rw     = 1'b0;
        bus.ex_md     = 1'b0;
        bus.ex_da     = '0;
        bus.ex_f      = '0;
        bus.mem_rdata = '0;
        bus.dof_valid = 1'b0;
        bus.dof_aa    = '0;
        bus.dof_ba    = '0;
        bus.dof_ma    = 1'b0;
        bus.dof_mb    = 1'b0;
    endtask

    task automatic set_ex(input logic md, input logic [AW-1:0] da, input logic [DW-1:0] f);
        bus.ex_valid = 1'b1;
        bus.ex_rw    = 1'b1;
        bus.ex_md    = md;
        bus.ex_da    = da;
        bus.ex_f     = f;
    endtask

    task automatic set_dof(input logic [AW-1:0] aa, input logic ma,
                           input logic [AW-1:0] ba, input logic mb);
        bus.dof_valid = 1'b1;
        bus.dof_aa    = aa;
        bus.dof_ma    = ma;
        bus.dof_ba    = ba;
        bus.dof_mb    = mb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.ex_f = 32'h0000_3C3C;
        repeat (2) tick();
        vectors++;
        if ({bus.RW, bus.DA, bus.BUS_D} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_wport: RW/DA/BUS_D got %b/%0d/%h want 0/0/0", bus.RW, bus.DA, bus.BUS_D);
        end
        vectors++;
        if ({bus.HA, bus.HB, bus.stall, bus.bubble, bus.stall_cnt} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: HA/HB/stall/bubble/cnt got %b%b%b%b/%0d want 0000/0",
                     bus.HA, bus.HB, bus.stall, bus.bubble, bus.stall_cnt);
        end
        vectors++;
        if (bus.FWD !== 32'h0000_3C3C) begin
            miscompares++;
            $display("FAIL reset_fwd: got %h want 00003c3c", bus.FWD);
        end
        rst_n = 1'b1;
        set_ex(1'b0, 5'd7, 32'h0000_1234);
        tick();
        idle_inputs();
        vectors++;
        if ({bus.RW, bus.DA, bus.BUS_D} !== {1'b1, 5'd7, 32'h0000_1234}) begin
            miscompares++;
            $display("FAIL pre_reset_write: RW/DA/BUS_D got %b/%0d/%h want 1/7/00001234", bus.RW, bus.DA, bus.BUS_D);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.RW, bus.DA, bus.stall_cnt} !== {1'b0, 5'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL async_reset: RW/DA/cnt got %b/%0d/%0d want 0/0/0", bus.RW, bus.DA, bus.stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_use();
        idle_inputs();
        set_ex(1'b0, 5'd3, 32'h0000_0055);
        set_dof(5'd3, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({bus.HA, bus.HB, bus.stall, bus.FWD} !== {3'b100, 32'h0000_0055}) begin
            miscompares++;
            $display("FAIL alu_use_fwd: HA/HB/stall/FWD got %b%b%b/%h want 100/00000055",
                     bus.HA, bus.HB, bus.stall, bus.FWD);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if ({bus.RW, bus.DA, bus.BUS_D} !== {1'b1, 5'd3, 32'h0000_0055}) begin
            miscompares++;
            $display("FAIL alu_use_write: RW/DA/BUS_D got %b/%0d/%h want 1/3/00000055", bus.RW, bus.DA, bus.BUS_D);
        end
        // Both operands from the same EX result forward together.
        set_ex(1'b0, 5'd9, 32'h0000_A5A5);
        set_dof(5'd9, 1'b0, 5'd9, 1'b0);
        #1;
        vectors++;
        if ({bus.HA, bus.HB, bus.stall, bus.FWD} !== {3'b110, 32'h0000_A5A5}) begin
            miscompares++;
            $display("FAIL dual_fwd: HA/HB/stall/FWD got %b%b%b/%h want 110/0000a5a5",
                     bus.HA, bus.HB, bus.stall, bus.FWD);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_ex(1'b1, 5'd4, 32'h0000_0BAD);
        set_dof(5'd0, 1'b0, 5'd4, 1'b0);
        #1;
        vectors++;
        if ({bus.stall, bus.bubble, bus.HB} !== 3'b110) begin
            miscompares++;
            $display("FAIL load_use_ex: stall/bubble/HB got %b%b%b want 110", bus.stall, bus.bubble, bus.HB);
        end
        tick();
        bus.ex_valid  = 1'b0;
        bus.mem_rdata = 32'h0000_DEAD;
        #1;
        vectors++;
        if ({bus.stall, bus.HB, bus.RW, bus.DA, bus.BUS_D} !== {3'b101, 5'd4, 32'h0000_DEAD}) begin
            miscompares++;
            $display("FAIL load_use_wb: stall/HB/RW/DA/BUS_D got %b%b%b/%0d/%h want 101/4/0000dead",
                     bus.stall, bus.HB, bus.RW, bus.DA, bus.BUS_D);
        end
        tick();
        vectors++;
        if ({bus.stall, bus.HB, bus.stall_cnt} !== {2'b00, 16'd2}) begin
            miscompares++;
            $display("FAIL load_use_done: stall/HB/cnt got %b%b/%0d want 00/2", bus.stall, bus.HB, bus.stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_mixed();
        idle_inputs();
        set_ex(1'b0, 5'd6, 32'h0000_0066);
        tick();
        set_ex(1'b0, 5'd5, 32'h0000_0077);
        set_dof(5'd5, 1'b0, 5'd6, 1'b0);
        #1;
        vectors++;
        if ({bus.stall, bus.HA, bus.HB} !== 3'b100) begin
            miscompares++;
            $display("FAIL mixed_stall: stall/HA/HB got %b%b%b want 100", bus.stall, bus.HA, bus.HB);
        end
        tick();
        // EX was bubbled; the ALU result for r5 now sits in WB, so DOF waits once more.
        bus.ex_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.stall, bus.HA, bus.RW, bus.DA, bus.BUS_D} !== {3'b101, 5'd5, 32'h0000_0077}) begin
            miscompares++;
            $display("FAIL mixed_wb: stall/HA/RW/DA/BUS_D got %b%b%b/%0d/%h want 101/5/00000077",
                     bus.stall, bus.HA, bus.RW, bus.DA, bus.BUS_D);
        end
        tick();
        vectors++;
        if ({bus.stall, bus.HA, bus.HB, bus.stall_cnt} !== {3'b000, 16'd4}) begin
            miscompares++;
            $display("FAIL mixed_clear: stall/HA/HB/cnt got %b%b%b/%0d want 000/4",
                     bus.stall, bus.HA, bus.HB, bus.stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_masking();
        idle_inputs();
        set_ex(1'b0, 5'd5, 32'h0000_0011);
        set_dof(5'd5, 1'b1, 5'd5, 1'b1);
        #1;
        vectors++;
        if ({bus.HA, bus.HB, bus.stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL mask_ma_mb: HA/HB/stall got %b%b%b want 000", bus.HA, bus.HB, bus.stall);
        end
        set_ex(1'b0, 5'd0, 32'h0000_0099);
        set_dof(5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({bus.HA, bus.HB, bus.stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL r0_ex: HA/HB/stall got %b%b%b want 000", bus.HA, bus.HB, bus.stall);
        end
        tick();
        bus.ex_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.RW, bus.stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL r0_wb: RW/stall got %b%b want 00", bus.RW, bus.stall);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        set_ex(1'b0, 5'd8, 32'h0000_0088);
        tick();
        bus.ex_valid = 1'b0;
        set_dof(5'd8, 1'b0, 5'd0, 1'b0);
        #1;
        vectors++;
        if ({bus.stall, bus.HA} !== 2'b10) begin
            miscompares++;
            $display("FAIL two_ahead_stall: stall/HA got %b%b want 10", bus.stall, bus.HA);
        end
        tick();
        vectors++;
        if ({bus.stall, bus.HA, bus.stall_cnt} !== {2'b00, 16'd5}) begin
            miscompares++;
            $display("FAIL two_ahead_clear: stall/HA/cnt got %b%b/%0d want 00/5", bus.stall, bus.HA, bus.stall_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        // A load stuck in EX against a matching reader stalls every cycle.
        set_ex(1'b1, 5'd4, 32'h0);
        set_dof(5'd0, 1'b0, 5'd4, 1'b0);
        repeat (65529) tick();
        vectors++;
        if (bus.stall_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_before: cnt got %h want fffe", bus.stall_cnt);
        end
        tick();
        vectors++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach: cnt got %h want ffff", bus.stall_cnt);
        end
        repeat (9) tick();
        vectors++;
        if ({bus.stall, bus.stall_cnt} !== {1'b1, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL sat_hold: stall/cnt got %b/%h want 1/ffff", bus.stall, bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        // WB holds the load from the saturation run; only the WB match stalls now.
        bus.ex_valid = 1'b0;
        #1;
        vectors++;
        if ({bus.stall, bus.RW} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_stall_pre: stall/RW got %b%b want 11", bus.stall, bus.RW);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.stall, bus.bubble, bus.RW, bus.stall_cnt} !== {3'b000, 16'd0}) begin
            miscompares++;
            $display("FAIL mid_stall_reset: stall/bubble/RW/cnt got %b%b%b/%0d want 000/0",
                     bus.stall, bus.bubble, bus.RW, bus.stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu_use();
        test_load_use();
        test_mixed();
        test_masking();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
